// File: rtl/uart_sha_pkg.sv
// ---------------------------------------------------------------------------
// uart_sha_pkg
// Shared types and constants for the UART front end of the SHA hashing
// controller: loader FSM states, command/response byte values and the byte
// offsets of each field inside the 84-byte job payload.
// ---------------------------------------------------------------------------
package uart_sha_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        JOB_PEND = 2'd2
    } loader_state_t;

    // Command bytes recognised only while idle
    localparam logic [7:0] CMD_RESET   = 8'h52;  // 'R'
    localparam logic [7:0] CMD_HELLO   = 8'h48;  // 'H'

    // Response bytes sent back toward uart_tx
    localparam logic [7:0] RSP_OK      = 8'h4F;  // 'O'
    localparam logic [7:0] RSP_HELLO   = 8'h31;  // '1'
    localparam logic [7:0] RSP_ERR     = 8'h45;  // 'E'
    localparam logic [7:0] RSP_START   = 8'h53;  // 'S'
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // 'T'

    // Payload layout (byte offsets)
    localparam int OFS_DATA   = 0;
    localparam int OFS_STATE  = 12;
    localparam int OFS_TARGET = 44;
    localparam int OFS_NONCE  = 76;
    localparam int OFS_POS    = 80;
    localparam int JOB_BYTES  = 84;

    // Acknowledgement for a byte received while idle
    function automatic logic [7:0] idle_response(input logic [7:0] b);
        if (b == CMD_HELLO) begin
            return RSP_HELLO;
        end else if (b == CMD_RESET) begin
            return RSP_OK;
        end
        return RSP_ERR;
    endfunction

endpackage

// File: rtl/job_timeout_ctr.sv
// ---------------------------------------------------------------------------
// job_timeout_ctr
// Idle-cycle watchdog. Counts cycles while enabled, restarts on clear, and
// raises o_expired combinationally in the cycle the count sits at
// TIMEOUT_CYCLES-1 (and wraps to zero on that cycle).
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   i_clear    restart the count (priority over enable)
//   i_enable   count this cycle
//   o_expired  one-cycle pulse when the limit is reached
// ---------------------------------------------------------------------------
module job_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int             W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0]   LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_count;

    assign o_expired = i_enable && !i_clear && (r_count == LIMIT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_clear || o_expired) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + W'(1);
        end
    end

endmodule

// File: rtl/uart_job_loader.sv
// ---------------------------------------------------------------------------
// uart_job_loader
// Front end of the SHA hashing controller. Interprets the 'R'/'H' command
// protocol on the uart_rx byte stream, assembles an 84-byte job payload into
// typed fields, offers it downstream on a valid/ready handshake and returns
// one-byte acknowledgements toward uart_tx. A stalled payload is abandoned
// after TIMEOUT_CYCLES idle cycles.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   in_valid/in_data/in_ready received byte stream
//   job_valid/job_ready       assembled job handshake
//   job_data      bytes 0..11,  byte i at [8i+:8]
//   job_state     bytes 12..43, big-endian (byte 12 at [255:248])
//   job_target    bytes 44..75, byte 44+k at [8k+:8]
//   job_nonce_base bytes 76..79, big-endian
//   job_position  bytes 80..83, big-endian
//   abort         one-cycle pulse: downstream hashing must reset
//   rsp_valid/rsp_data/rsp_ready  single-entry response byte slot
// ---------------------------------------------------------------------------
module uart_job_loader
    import uart_sha_pkg::*;
#(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int TIMEOUT_CYCLES = 10_000_000,
    parameter int JOB_BYTES      = uart_sha_pkg::JOB_BYTES
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         job_valid,
    input  logic         job_ready,
    output logic [95:0]  job_data,
    output logic [255:0] job_state,
    output logic [255:0] job_target,
    output logic [31:0]  job_nonce_base,
    output logic [31:0]  job_position,
    output logic         abort,
    output logic         rsp_valid,
    output logic [7:0]   rsp_data,
    input  logic         rsp_ready
);

    localparam int CNT_W = $clog2(JOB_BYTES);

    // CLK_FREQ is informational; an illegally parameterised instance keeps
    // in_ready low so the mistake is visible as soon as it is simulated.
    localparam bit PARAMS_OK = (CLK_FREQ > 0) && (JOB_BYTES == 84) &&
                               (TIMEOUT_CYCLES >= 2);

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on a clock edge
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Holds in_ready low for the first cycle out of reset
    logic r_open;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_open <= 1'b0;
        end else begin
            r_open <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State and handshakes
    // ------------------------------------------------------------------
    loader_state_t    r_state, w_state_next;
    logic [CNT_W-1:0] r_byte_cnt, w_byte_cnt_next;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_data;
    logic             r_job_valid;
    logic             r_abort;

    logic             w_in_ready;
    logic             w_xfer;
    logic             w_job_xfer;
    logic             w_rsp_xfer;
    logic             w_expired;
    logic             w_to_enable;
    logic             w_to_clear;

    logic             w_rsp_load;
    logic [7:0]       w_rsp_byte;
    logic             w_abort_next;
    logic             w_job_set;
    logic             w_job_clr;
    logic             w_payload_we;

    assign w_in_ready = PARAMS_OK && r_open && !r_rsp_valid && (r_state != JOB_PEND);
    assign w_xfer     = in_valid && w_in_ready;
    assign w_job_xfer = r_job_valid && job_ready;
    assign w_rsp_xfer = r_rsp_valid && rsp_ready;

    // Watchdog runs only between payload bytes, and pauses while the
    // response slot is occupied (the sender cannot be blamed for that).
    assign w_to_clear  = (r_state != RECV) || w_xfer;
    assign w_to_enable = (r_state == RECV) && !r_rsp_valid && !w_xfer;

    job_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rstn      (w_rst_n),
        .i_clear   (w_to_clear),
        .i_enable  (w_to_enable),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= IDLE;
            r_byte_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_byte_cnt <= w_byte_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_byte_cnt_next = r_byte_cnt;
        w_rsp_load      = 1'b0;
        w_rsp_byte      = r_rsp_data;
        w_abort_next    = 1'b0;
        w_job_set       = 1'b0;
        w_job_clr       = 1'b0;
        w_payload_we    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_rsp_load = 1'b1;
                    w_rsp_byte = idle_response(in_data);
                    if (in_data == CMD_HELLO) begin
                        w_byte_cnt_next = '0;
                        w_state_next    = RECV;
                    end else if (in_data == CMD_RESET) begin
                        w_abort_next = 1'b1;
                    end
                end
            end

            RECV: begin
                // Every byte here is payload, even 'R' and 'H'
                if (w_xfer) begin
                    w_payload_we = 1'b1;
                    if (r_byte_cnt == CNT_W'(JOB_BYTES - 1)) begin
                        w_byte_cnt_next = '0;
                        w_job_set       = 1'b1;
                        w_state_next    = JOB_PEND;
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + CNT_W'(1);
                    end
                end else if (w_expired) begin
                    w_rsp_load      = 1'b1;
                    w_rsp_byte      = RSP_TIMEOUT;
                    w_abort_next    = 1'b1;
                    w_byte_cnt_next = '0;
                    w_state_next    = IDLE;
                end
            end

            JOB_PEND: begin
                // The 'H' ack left the slot before payload could arrive,
                // so the 'S' always finds the slot empty.
                if (w_job_xfer) begin
                    w_job_clr    = 1'b1;
                    w_rsp_load   = 1'b1;
                    w_rsp_byte   = RSP_START;
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_job_valid <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_abort <= w_abort_next;

            if (w_rsp_load) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_rsp_byte;
            end else if (w_rsp_xfer) begin
                r_rsp_valid <= 1'b0;
            end

            if (w_job_set) begin
                r_job_valid <= 1'b1;
            end else if (w_job_clr) begin
                r_job_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Payload storage: one register per byte, written when the count
    // points at it. Contents persist until the next payload overwrites.
    // ------------------------------------------------------------------
    genvar gi;

    for (gi = 0; gi < JOB_BYTES; gi++) begin : g_byte
        logic [7:0] r_byte;

        always_ff @(posedge clk or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_byte <= 8'h00;
            end else if (w_payload_we && (r_byte_cnt == CNT_W'(gi))) begin
                r_byte <= in_data;
            end
        end
    end

    // Field views of the payload bytes
    for (gi = 0; gi < 12; gi++) begin : g_data
        assign job_data[8*gi +: 8] = g_byte[OFS_DATA + gi].r_byte;
    end

    for (gi = 0; gi < 32; gi++) begin : g_state
        assign job_state[255 - 8*gi -: 8]  = g_byte[OFS_STATE + gi].r_byte;
        assign job_target[8*gi +: 8]       = g_byte[OFS_TARGET + gi].r_byte;
    end

    for (gi = 0; gi < 4; gi++) begin : g_words
        assign job_nonce_base[31 - 8*gi -: 8] = g_byte[OFS_NONCE + gi].r_byte;
        assign job_position[31 - 8*gi -: 8]   = g_byte[OFS_POS + gi].r_byte;
    end

    assign in_ready  = w_in_ready;
    assign job_valid = r_job_valid;
    assign abort     = r_abort;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: doc/uart_job_loader.md
Name: uart_job_loader

Overview:
- Upstream stage of the SHA hashing controller. Consumes the raw byte stream from uart_rx and runs the 'R'/'H' command protocol.
- Assembles the 84-byte job payload into typed fields: data, midstate, target, nonce base, position. Presents a complete job on a valid/ready handshake and emits one-byte acknowledgements toward uart_tx.
- Removes byte-counting and unpacking from the hashing controller, and adds an inter-byte timeout so a truncated job cannot wedge the link.

Parameters:
- CLK_FREQ, 100_000_000, clock frequency in Hz. Documentation only; not used in arithmetic.
- TIMEOUT_CYCLES, 10_000_000, idle cycles allowed between payload bytes before abort. Minimum 2.
- JOB_BYTES, 84, payload length. Fixed; changing it is illegal.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset. One clock domain; the polarity and synchronicity are fixed.
- in_valid  in  1  received byte valid.
- in_data  in  8  received byte.
- in_ready  out  1  loader accepts in_data this cycle.
- job_valid  out  1  assembled job available.
- job_ready  in  1  downstream accepts the job.
- job_data  out  96  payload bytes 0..11; byte i at [8i+:8].
- job_state  out  256  payload bytes 12..43, big-endian; byte 12 at [255:248].
- job_target  out  256  payload bytes 44..75; byte 44+k at [8k+:8].
- job_nonce_base  out  32  payload bytes 76..79, big-endian.
- job_position  out  32  payload bytes 80..83, big-endian.
- abort  out  1  one-cycle pulse: downstream hashing must reset.
- rsp_valid  out  1  response byte pending.
- rsp_data  out  8  response byte.
- rsp_ready  in  1  uart_tx accepts the response.

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE; in_ready 0 for the first cycle, then per rule; job_valid 0; rsp_valid 0; rsp_data 0; abort 0; all job_* 0; byte count 0; timeout count 0.
- Byte transfer: occurs when in_valid && in_ready. in_ready = !rsp_valid && state != JOB_PEND.
- Response slot: single entry. rsp_valid rises the cycle after the triggering event. It is held, with rsp_data stable, until rsp_ready; it clears the cycle after the handshake.
- IDLE:
  - 'H' (0x48) -> rsp '1'; byte count 0; go to RECV.
  - 'R' (0x52) -> rsp 'O'; abort pulse; stay in IDLE.
  - Any other byte -> rsp 'E'; stay in IDLE.
- RECV:
  - Every byte is raw payload. 'R' and 'H' are NOT interpreted as commands here.
  - Byte n is written to its field at the offsets above; count increments.
  - On byte 83: count resets to 0, job_valid goes 1 on the next cycle, go to JOB_PEND.
  - No response byte is produced per payload byte.
- Timeout (RECV only):
  - The counter increments each cycle with no transfer and clears on each transfer.
  - It is frozen while rsp_valid is high.
  - Reaching TIMEOUT_CYCLES-1 -> rsp 'T'; abort pulse; byte count 0; go to IDLE. Partially written fields keep stale contents.
  - The counter is idle in IDLE and JOB_PEND.
- JOB_PEND:
  - job_* fields are stable while job_valid is high.
  - On job_valid && job_ready: job_valid clears next cycle, rsp 'S', return to IDLE.
  - If the job and response handshakes would need the slot simultaneously, this cannot occur, because the slot is empty on entry ('H' ack was consumed before in_ready reopened).
- Field registers hold their last job after acceptance. Only the next payload overwrites them.
- A reset assertion mid-RECV or mid-JOB_PEND immediately returns all outputs to their reset values. No 'T' or 'S' response is emitted.
- The loader never drops an in_data byte once in_ready is high. Back-pressure is via in_ready only.

Decomposition:
- Package uart_sha_pkg:
  - loader_state_t enum {IDLE, RECV, JOB_PEND}.
  - Byte-value constants CMD_RESET 'R', CMD_HELLO 'H'.
  - Response constants RSP_OK 'O', RSP_HELLO '1', RSP_ERR 'E', RSP_START 'S', RSP_TIMEOUT 'T'.
  - Field offset constants OFS_DATA 0, OFS_STATE 12, OFS_TARGET 44, OFS_NONCE 76, OFS_POS 80, JOB_BYTES 84.
- Sub-module job_timeout_ctr (clear, enable, expired pulse; width $clog2(TIMEOUT_CYCLES)). The hashing controller reuses it.

Test Plan:
- Reset, then 'X' -> in_ready 1; rsp 'E' after one cycle; state stays IDLE; job_valid 0.
- 'R' in IDLE with rsp_ready tied 1 -> abort high exactly 1 cycle; rsp_data 'O'; in_ready low while rsp_valid is high.
- 'H' then payload bytes 0x00..0x53 -> rsp '1':
  - job_data[7:0]=0x00, job_state[255:248]=0x0C, job_target[7:0]=0x2C.
  - job_nonce_base=0x4C4D4E4F, job_position=0x50515253.
  - Hold job_ready 0 for 20 cycles: fields stable, in_ready 0. Then raise job_ready: rsp 'S'.
- 'H', 10 payload bytes, then silence with TIMEOUT_CYCLES=16 -> rsp 'T' and abort 16 cycles after the last byte. A following 'H' plus a full payload yields a correct job.
- Payload containing 0x52 and 0x48 at bytes 5 and 6 -> no abort, no extra rsp; job_data bytes 5,6 = 0x52, 0x48.
- Hold rsp_ready 0 after 'H' with in_valid held -> in_ready stays 0, no byte consumed. Release: the next byte lands at payload offset 0. Also assert rstn low mid-payload -> all outputs 0 immediately.
